// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencing controller: LOAD, NR rounds of STAGE_LAT cycles, then a DONE handshake.
// Optional abort input is built when AES_CTRL_ABORT_EN is defined.
module aes_round_ctrl #(
  parameter int unsigned NR        = 10,
  parameter int unsigned STAGE_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  output logic       done_valid,
  input  logic       done_ready,
  output logic       load_state,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       mix_bypass,
  output logic       busy
`ifdef AES_CTRL_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam int unsigned STG_W = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGE_LAT - 1);
  localparam logic [3:0]       NR_IDX   = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [STG_W-1:0] r_stage;
  logic [STG_W-1:0] w_stage_nxt;
  logic [3:0]       r_round;
  logic [3:0]       w_round_nxt;
  logic             w_abort;

  logic r_start_ready;
  logic r_busy;
  logic r_load_state;
  logic r_round_en;
  logic r_mix_bypass;
  logic r_done_valid;

  logic w_start_ready_nxt;
  logic w_busy_nxt;
  logic w_load_state_nxt;
  logic w_round_en_nxt;
  logic w_mix_bypass_nxt;
  logic w_done_valid_nxt;

`ifdef AES_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Next state/counters; strobes are pre-decoded from the next state so every output is a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_round_nxt = r_round;

    case (r_state)
      S_IDLE: begin
        if (start_valid && r_start_ready) begin
          w_state_nxt = S_LOAD;
          w_round_nxt = 4'd0;
          w_stage_nxt = '0;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_ROUND;
        w_round_nxt = 4'd1;
        w_stage_nxt = '0;
      end
      S_ROUND: begin
        if (r_stage == STG_LAST) begin
          if (r_round < NR_IDX) begin
            w_round_nxt = r_round + 4'd1;
            w_stage_nxt = '0;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_stage_nxt = r_stage + STG_W'(1);
        end
      end
      S_DONE: begin
        if (done_ready) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = 4'd0;
          w_stage_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = 4'd0;
        w_stage_nxt = '0;
      end
    endcase

    // Abort outranks everything outside IDLE, including a pending done handshake.
    if (w_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_round_nxt = 4'd0;
      w_stage_nxt = '0;
    end

    w_start_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt        = (w_state_nxt != S_IDLE);
    w_load_state_nxt  = (w_state_nxt == S_LOAD);
    w_round_en_nxt    = (w_state_nxt == S_ROUND) && (w_stage_nxt == STG_LAST);
    w_mix_bypass_nxt  = (w_state_nxt == S_ROUND) && (w_round_nxt == NR_IDX);
    w_done_valid_nxt  = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_stage       <= '0;
      r_round       <= 4'd0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_load_state  <= 1'b0;
      r_round_en    <= 1'b0;
      r_mix_bypass  <= 1'b0;
      r_done_valid  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_stage       <= w_stage_nxt;
      r_round       <= w_round_nxt;
      r_start_ready <= w_start_ready_nxt;
      r_busy        <= w_busy_nxt;
      r_load_state  <= w_load_state_nxt;
      r_round_en    <= w_round_en_nxt;
      r_mix_bypass  <= w_mix_bypass_nxt;
      r_done_valid  <= w_done_valid_nxt;
    end
  end

  assign start_ready = r_start_ready;
  assign busy        = r_busy;
  assign load_state  = r_load_state;
  assign round_en    = r_round_en;
  assign round_idx   = r_round;
  assign mix_bypass  = r_mix_bypass;
  assign done_valid  = r_done_valid;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: a behavioural AES-128 datapath follows the strobes and the
// FIPS-197 C.1 ciphertext is checked; a second instance covers NR=1, STAGE_LAT=1.
module tb_aes_round_ctrl;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_valid;
  logic       done_ready;
  logic       start_ready;
  logic       done_valid;
  logic       load_state;
  logic       round_en;
  logic [3:0] round_idx;
  logic       mix_bypass;
  logic       busy;
`ifdef AES_CTRL_ABORT_EN
  logic       abort;
`endif

  logic       s1_start_valid;
  logic       s1_done_ready;
  logic       s1_start_ready;
  logic       s1_done_valid;
  logic       s1_load_state;
  logic       s1_round_en;
  logic [3:0] s1_round_idx;
  logic       s1_mix_bypass;
  logic       s1_busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] rk [0:15];
  logic [127:0] dp;

  aes_round_ctrl #(.NR(10), .STAGE_LAT(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .done_valid(done_valid), .done_ready(done_ready), .load_state(load_state),
    .round_en(round_en), .round_idx(round_idx), .mix_bypass(mix_bypass), .busy(busy)
`ifdef AES_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  aes_round_ctrl #(.NR(1), .STAGE_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(s1_start_valid), .start_ready(s1_start_ready),
    .done_valid(s1_done_valid), .done_ready(s1_done_ready), .load_state(s1_load_state),
    .round_en(s1_round_en), .round_idx(s1_round_idx), .mix_bypass(s1_mix_bypass), .busy(s1_busy)
`ifdef AES_CTRL_ABORT_EN
    , .abort(1'b0)
`endif
  );

  // ---------------- AES-128 reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv  = 8'h01;
    logic [7:0] base = b;
    logic [7:0] e    = 8'hfe;
    logic [7:0] rl;
    logic [7:0] s;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    if (b == 8'h00) inv = 8'h00;
    rl = inv;
    s  = inv;
    for (int k = 0; k < 4; k++) begin
      rl = {rl[6:0], rl[7]};
      s  = s ^ rl;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c+r] = sbox(a[4*((c+r)%4)+r]);
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
        b[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
        b[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
        b[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  task automatic init_keys();
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Registered datapath stand-in driven purely by the controller strobes.
  always @(posedge clk) begin
    if (load_state)    dp <= PT ^ rk[0];
    else if (round_en) dp <= aes_round(dp, rk[round_idx], mix_bypass);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [9:0] obs;
    tick();
    obs = {start_ready, busy, load_state, round_en, mix_bypass, done_valid, round_idx};
    n_cmp++;
    if (obs !== 10'b10_0000_0000) begin
      n_err++;
      $display("FAIL reset_main: got %b want %b", obs, 10'b10_0000_0000);
    end
    obs = {s1_start_ready, s1_busy, s1_load_state, s1_round_en, s1_mix_bypass, s1_done_valid,
           s1_round_idx};
    n_cmp++;
    if (obs !== 10'b10_0000_0000) begin
      n_err++;
      $display("FAIL reset_lat1: got %b want %b", obs, 10'b10_0000_0000);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [9:0] obs, exp;
    logic       idle, ld, re, mb, dv;
    logic [3:0] ri;
    done_ready  = 1'b1;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      ld   = (k == 1);
      re   = (k >= 4) && (k <= 31) && ((k - 1) % 3 == 0);
      mb   = (k >= 29) && (k <= 31);
      dv   = (k == 32);
      idle = (k >= 33);
      ri   = (k == 1) ? 4'd0 : (k <= 31) ? 4'((k - 2) / 3 + 1) : (k == 32) ? 4'd10 : 4'd0;
      exp  = {idle, !idle, ld, re, mb, dv, ri};
      obs  = {start_ready, busy, load_state, round_en, mix_bypass, done_valid, round_idx};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL single_cycle%0d: got %b want %b", k, obs, exp);
      end
      if (k == 32) begin
        n_cmp++;
        if (dp !== CT) begin
          n_err++;
          $display("FAIL single_ct: got %h want %h", dp, CT);
        end
      end
      tick();
    end
  endtask

  task automatic test_done_hold();
    logic [6:0] obs;
    int n = 0;
    done_ready  = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    while (!done_valid && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (dp !== CT || !done_valid) begin
      n_err++;
      $display("FAIL hold_done_ct: got valid=%b %h want valid=1 %h", done_valid, dp, CT);
    end
    start_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      obs = {done_valid, round_idx, start_ready, load_state};
      n_cmp++;
      if (obs !== 7'b1_1010_00) begin
        n_err++;
        $display("FAIL hold_stable%0d: got %b want %b", i, obs, 7'b1_1010_00);
      end
      tick();
    end
    done_ready = 1'b1;
    tick();
    n_cmp++;
    if ({start_ready, done_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL hold_release: got ready/valid %b want 10", {start_ready, done_valid});
    end
    tick();
    start_valid = 1'b0;
    n_cmp++;
    if (load_state !== 1'b1) begin
      n_err++;
      $display("FAIL hold_next_accept: got load_state %b want 1", load_state);
    end
    n = 0;
    while (!start_ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, rcnt = 0, lcnt = 0, dcnt = 0;
    int acc_cyc [3];
    // 32 busy cycles (LOAD, 30 round cycles, DONE) plus the mandatory idle bubble.
    int gap = 1 + 10 * 3 + 1 + 1;
    done_ready  = 1'b1;
    start_valid = 1'b1;
    for (int cyc = 0; cyc < 110; cyc++) begin
      if (start_ready && start_valid && acc < 3) begin
        acc_cyc[acc] = cyc;
        acc++;
      end
      if (round_en)   rcnt++;
      if (load_state) lcnt++;
      if (done_valid) begin
        dcnt++;
        n_cmp++;
        if (dp !== CT) begin
          n_err++;
          $display("FAIL b2b_ct%0d: got %h want %h", dcnt, dp, CT);
        end
      end
      tick();
      if (acc == 3) start_valid = 1'b0;
    end
    n_cmp++;
    if (acc != 3 || dcnt != 3 || lcnt != 3 || rcnt != 30) begin
      n_err++;
      $display("FAIL b2b_counts: got acc=%0d done=%0d load=%0d round_en=%0d want 3 3 3 30",
               acc, dcnt, lcnt, rcnt);
    end
    n_cmp++;
    if (acc == 3 && (acc_cyc[1] - acc_cyc[0] != gap || acc_cyc[2] - acc_cyc[1] != gap)) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d,%0d want %0d", acc_cyc[1] - acc_cyc[0],
               acc_cyc[2] - acc_cyc[1], gap);
    end
  endtask

  task automatic test_lat1();
    logic [9:0] obs;
    logic [9:0] exp [4];
    exp[0] = 10'b01_1000_0000;
    exp[1] = 10'b01_0110_0001;
    exp[2] = 10'b01_0001_0001;
    exp[3] = 10'b10_0000_0000;
    s1_done_ready  = 1'b1;
    s1_start_valid = 1'b1;
    tick();
    s1_start_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      obs = {s1_start_ready, s1_busy, s1_load_state, s1_round_en, s1_mix_bypass, s1_done_valid,
             s1_round_idx};
      n_cmp++;
      if (obs !== exp[k]) begin
        n_err++;
        $display("FAIL lat1_cycle%0d: got %b want %b", k + 1, obs, exp[k]);
      end
      tick();
    end
  endtask

  task automatic run_block(input string tag);
    int n = 0;
    done_ready  = 1'b1;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    while (!done_valid && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!done_valid || dp !== CT) begin
      n_err++;
      $display("FAIL %s_ct: got valid=%b %h want valid=1 %h", tag, done_valid, dp, CT);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs;
    int n = 0;
    done_ready  = 1'b1;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    while (round_idx != 4'd5 && n < 50) begin
      tick();
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {start_ready, busy, load_state, round_en, mix_bypass, done_valid, round_idx};
    n_cmp++;
    if (n >= 50 || obs !== 10'b10_0000_0000) begin
      n_err++;
      $display("FAIL midreset_vals: got %b want %b (wait=%0d)", obs, 10'b10_0000_0000, n);
    end
    #2 rst_n = 1'b1;
    tick();
    run_block("midreset");
  endtask

`ifdef AES_CTRL_ABORT_EN
  task automatic test_abort();
    logic [9:0] obs;
    int n = 0, strobes = 0;
    done_ready  = 1'b1;
    start_valid = 1'b1;
    abort       = 1'b1;
    tick();
    start_valid = 1'b0;
    abort       = 1'b0;
    n_cmp++;
    if (load_state !== 1'b1) begin
      n_err++;
      $display("FAIL abort_idle_ignored: got load_state %b want 1", load_state);
    end
    while (round_idx != 4'd7 && n < 50) begin
      tick();
      n++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    obs = {start_ready, busy, load_state, round_en, mix_bypass, done_valid, round_idx};
    n_cmp++;
    if (obs !== 10'b10_0000_0000) begin
      n_err++;
      $display("FAIL abort_round7: got %b want %b", obs, 10'b10_0000_0000);
    end
    for (int i = 0; i < 40; i++) begin
      if (round_en || done_valid || load_state) strobes++;
      tick();
    end
    n_cmp++;
    if (strobes != 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d strobe cycles want 0", strobes);
    end
    run_block("abort_next");
    done_ready  = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    n = 0;
    while (!done_valid && n < 100) begin
      tick();
      n++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({start_ready, done_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL abort_done: got ready/valid %b want 10", {start_ready, done_valid});
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    start_valid    = 1'b0;
    done_ready     = 1'b0;
    s1_start_valid = 1'b0;
    s1_done_ready  = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    abort          = 1'b0;
`endif
    init_keys();
    test_reset();
    test_single();
    test_done_hold();
    test_back_to_back();
    test_lat1();
    test_reset_mid();
`ifdef AES_CTRL_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
